// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first, one bit per clock
// through a single full_subtractor cell and a stored borrow flip-flop.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bo;
  logic             accept, last_bit;

  full_subtractor u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Datapath: difference bits enter at the MSB so diff is aligned after WIDTH shifts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        a_sr     <= a;
        b_sr     <= b;
        borrow_q <= borrow_in;
        cnt      <= '0;
        diff     <= '0;
        busy     <= 1'b1;
      end else if (state == ST_RUN) begin
        diff     <= {cell_d, diff[WIDTH-1:1]};
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        borrow_q <= cell_bo;
        cnt      <= cnt + CW'(1);
        if (last_bit) begin
          busy       <= 1'b0;
          borrow_out <= cell_bo;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4) and the
// full_subtractor cell, against an integer-arithmetic reference model.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  logic       start8, bi8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bi4, busy4, done4, bo4;
  logic [3:0] a4, b4, diff4;
  logic       fx, fy, fbi, fd, fbo;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  full_subtractor fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, wrapped to w bits
  function automatic void model(input int w, input int a, input int b, input int bi,
                                output int d, output int bo);
    int r;
    r  = a - b - bi;
    bo = (r < 0) ? 1 : 0;
    d  = r & ((1 << w) - 1);
  endfunction

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bi, input string tag);
    start8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy8), 32'd1);
    chk({tag, "_done_e0"}, 32'(done8), 32'd0);
  endtask

  task automatic wait8(input logic [7:0] ea, input logic [7:0] eb, input logic ebi,
                       input bit noise, input bit drop, input string tag);
    int cyc, bcnt, d, bo;
    bit seen;
    model(8, int'(ea), int'(eb), int'(ebi), d, bo);
    cyc = 1; bcnt = 1; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (noise) begin
        if (cyc >= 3 && cyc <= 6) begin
          start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        end else begin
          start8 = 1'b0;
        end
      end
      if (done8) seen = 1'b1;
      else if (busy8) bcnt++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
    chk({tag, "_diff"}, 32'(diff8), 32'(d));
    chk({tag, "_borrow_out"}, 32'(bo8), 32'(bo));
    if (drop) begin
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, 32'(done8), 32'd0);
      chk({tag, "_diff_hold"}, 32'(diff8), 32'(d));
      chk({tag, "_bo_hold"}, 32'(bo8), 32'(bo));
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int cyc, d, bo;
    model(4, int'(a), int'(b), int'(bi), d, bo);
    start4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w4_latency", 32'(cyc), 32'd5);
    chk("w4_diff", 32'(diff4), 32'(d));
    chk("w4_borrow_out", 32'(bo4), 32'(bo));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rbi;
    int         r;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    fx = 1'b0; fy = 1'b0; fbi = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bo", 32'(bo8), 32'd0);
    chk("rst_diff4", 32'(diff4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations
    launch8(8'h05, 8'h03, 1'b0, "basic");
    wait8(8'h05, 8'h03, 1'b0, 1'b0, 1'b1, "basic");
    chk("basic_diff_const", 32'(diff8), 32'h02);
    launch8(8'h03, 8'h05, 1'b0, "under");
    wait8(8'h03, 8'h05, 1'b0, 1'b0, 1'b1, "under");
    chk("under_diff_const", 32'(diff8), 32'hFE);
    launch8(8'h00, 8'h00, 1'b1, "chain");
    wait8(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "chain");
    chk("chain_diff_const", 32'(diff8), 32'hFF);
    chk("chain_bo_const", 32'(bo8), 32'd1);

    // Reset in the middle of a run while borrow_out still holds 1
    launch8(8'hA5, 8'h3C, 1'b0, "midrst");
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_bo", 32'(bo8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    r = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) r++;
    end
    chk("midrst_no_done", 32'(r), 32'd0);
    launch8(8'h10, 8'h01, 1'b0, "after_rst");
    wait8(8'h10, 8'h01, 1'b0, 1'b0, 1'b1, "after_rst");
    chk("after_rst_diff_const", 32'(diff8), 32'h0F);

    launch8(8'hFF, 8'h00, 1'b1, "noborrow");
    wait8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, "noborrow");
    chk("noborrow_bo_const", 32'(bo8), 32'd0);

    // start held with fresh operands during RUN must be ignored
    launch8(8'h5A, 8'h27, 1'b0, "busyign");
    wait8(8'h5A, 8'h27, 1'b0, 1'b1, 1'b0, "busyign");
    r = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) r++;
    end
    chk("busyign_single_done", 32'(r), 32'd0);

    // Back-to-back: second start issued in the done cycle
    launch8(8'h77, 8'h11, 1'b0, "b2b_first");
    wait8(8'h77, 8'h11, 1'b0, 1'b0, 1'b0, "b2b_first");
    launch8(8'h80, 8'h01, 1'b0, "b2b_second");
    chk("b2b_diff_cleared", 32'(diff8), 32'd0);
    wait8(8'h80, 8'h01, 1'b0, 1'b0, 1'b1, "b2b_second");
    chk("b2b_diff_const", 32'(diff8), 32'h7F);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      launch8(ra, rb, rbi, "rand");
      wait8(ra, rb, rbi, 1'b0, 1'b0, "rand");
    end

    // Exhaustive sweep at WIDTH=4
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          op4(4'(ia), 4'(ib), 1'(ic));

    // Cell truth table
    for (int i = 0; i < 8; i++) begin
      {fx, fy, fbi} = 3'(i);
      #1;
      r = int'(fx) - int'(fy) - int'(fbi);
      chk("cell_d", 32'(fd), 32'(r & 1));
      chk("cell_bo", 32'(fbo), (r < 0) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor that computes `a - b - borrow_in` one bit per clock, LSB first, through a stored borrow flip-flop. It is the inverse-direction companion of the team's ripple full-adder datapath: the adder cell chains carry spatially, and this block chains borrow temporally through a single cell. It serves as the area-minimal arithmetic unit in the digital-electronics-basics set, and downstream serial-arithmetic exercises start from it.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are 2 to 32.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin an operation; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge.
- `borrow_in`  input  1  initial borrow; sampled on the accepting edge.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when the result is valid.
- `diff`  output  WIDTH  result `(a - b - borrow_in) mod 2^WIDTH`.
- `borrow_out`  output  1  final borrow; high when `a < b + borrow_in` (unsigned).

## Operation
- **States:** IDLE and RUN.
- **Reset values:** state = IDLE, `busy`=0, `done`=0, `diff`=0, `borrow_out`=0. Internal shift registers, borrow flip-flop and bit counter also reset to 0.
- **IDLE to RUN:** on an edge with `start`=1:
  - load `a` and `b` into shift registers;
  - load `borrow_in` into the borrow flip-flop;
  - clear the bit counter and clear `diff`.
- **RUN, each edge:**
  - the 1-bit cell takes the LSBs of the shift registers and the stored borrow;
  - the difference bit shifts into the MSB of `diff`, and `diff` shifts right;
  - the operand registers shift right;
  - the borrow flip-flop takes the cell's borrow out;
  - the counter increments.
- **RUN to IDLE:** on the edge that processes bit WIDTH-1:
  - `diff` now holds the full result and `borrow_out` takes the final borrow;
  - `done` is set for exactly one cycle.
- **Cell equations:**
  - `d = x ^ y ^ bi`
  - `bo = (~x & y) | (~(x ^ y) & bi)`
- **`start` while RUN:** ignored. There is no queueing and operands are not resampled.
- **Result hold:** `diff` and `borrow_out` hold their values until the next accepted `start`, which clears `diff` to 0 on that edge. `borrow_out` keeps its old value until completion.
- **Input changes during RUN:** no effect on the computation.
- **Reset mid-operation:** the operation is abandoned, all outputs return to their reset values immediately, and no `done` is produced.

## Timing
- **Edge numbering:** E0 is the edge that accepts `start`. `busy`=1 from E0. Bit i is processed at edge E(i+1).
- **Completion:** at EWIDTH, `busy` falls to 0, `done` rises to 1, and `diff`/`borrow_out` become final. Latency is WIDTH clocks from acceptance to `done`.
- **`done` width:** `done` falls at EWIDTH+1 unless a new operation starts.
- **Back-to-back operations:** a `start` high during the `done` cycle is accepted at EWIDTH+1. The throughput is one result per WIDTH+1 cycles.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Shared package `serial_arith_pkg`:**
  - state enum `{ST_IDLE, ST_RUN}`;
  - default width constant `SERIAL_WIDTH_DEFAULT = 8`;
  - counter-width function `cnt_w(w) = $clog2(w)`.
- **Sub-module `full_subtractor`:** purely combinational, with ports x, y, bi, d, bo. It is instantiated once and verified standalone against its 8-row truth table.

## Test plan
- **Basic subtract:** WIDTH=8, a=0x05, b=0x03, borrow_in=0, start pulse. Required: after 8 cycles `done`=1 for one cycle, `diff`=0x02, `borrow_out`=0; `busy` high for exactly 8 cycles.
- **Underflow and borrow chain:**
  - a=0x03, b=0x05, borrow_in=0 gives `diff`=0xFE, `borrow_out`=1;
  - a=0x00, b=0x00, borrow_in=1 gives `diff`=0xFF, `borrow_out`=1.
- **No-borrow edge case:** a=0xFF, b=0x00, borrow_in=1 gives `diff`=0xFE, `borrow_out`=0. Exhaustive a/b/borrow_in sweep at WIDTH=4 compared against a reference model.
- **Busy behaviour:** `start` held high with new operands during cycles 2–5 of RUN. Required: ignored; the result equals the first operation's result and there is exactly one `done` pulse.
- **Reset mid-operation:** assert `rst` asynchronously in cycle 3 of RUN, mid-cycle. Required:
  - outputs reach 0 before the next edge and no `done` appears;
  - after release, 0x10-0x01 gives 0x0F with `borrow_out`=0.
- **Back-to-back:** `start` asserted during the `done` cycle with 0x80-0x01. Required: accepted on the next edge; second `done` WIDTH cycles later with `diff`=0x7F and `borrow_out`=0.
